cp0_exc_ctrl: RTL

//  Coprocessor-0 exception/interrupt responder at the M stage of the P7 pipeline.
//  - Consumes the exception code, PC and delay-slot flag carried into M by the pipeline registers.
//  - Raises Req, which flushes every pipeline register and steers fetch to 0x0000_4180.
//  - Holds SR, Cause, EPC and PRId.
//  - Serves mfc0 reads, mtc0 writes and eret.

---
 rtl/cp0_exc_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 exception/interrupt responder at the M stage.
//   Holds SR(12), Cause(13), EPC(14) and PRId(15). Serves mfc0 reads, mtc0 writes and eret.
//   It raises Req to flush the pipeline and redirect fetch to HandlerPC.
// Optional feature: define CP0_TIMER_EN to add Count(9), Compare(11) and a timer interrupt (TI).
//   TI is OR'ed into IP bit 15.
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   A1 / DOut              mfc0 read address / combinational read data (registered state only)
//   A2, DIn, WE            mtc0 write address, data, enable
//   M_PC, M_DelaySlot      PC and delay-slot flag of the instruction in M
//   M_EXCcode              exception code from M (0 = none)
//   HWInt                  level-sensitive external interrupt lines
//   EXLClr                 eret in M
//   EPCout                 EPC register value (eret target)
//   HandlerPC              constant handler entry address
//   Req                    exception/interrupt taken this cycle (combinational)
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID_VAL     = 32'h2024_0707,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] M_PC,
  input  logic        M_DelaySlot,
  input  logic [4:0]  M_EXCcode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCout,
  output logic [31:0] HandlerPC,
  output logic        Req
);

  // SR fields
  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  // Cause fields
  logic        bd_q;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;

  logic [5:0]  ip_next;
  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;

  assign ip_next = {HWInt[5] | ti_q, HWInt[4:0]};
`else
  assign ip_next = HWInt;
`endif

  assign int_req   = (|(ip_next & im_q)) & ie_q & ~exl_q;
  assign exc_req   = (M_EXCcode != 5'd0) & ~exl_q;
  assign Req       = int_req | exc_req;
  assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
  assign EPCout    = epc_q;
  assign HandlerPC = HANDLER_ADDR;

  always_comb begin
    DOut = 32'd0;
    unique case (A1)
      5'd12:   DOut = sr_val;
      5'd13:   DOut = cause_val;
      5'd14:   DOut = epc_q;
      5'd15:   DOut = PRID_VAL;
`ifdef CP0_TIMER_EN
      5'd9:    DOut = count_q;
      5'd11:   DOut = compare_q;
`endif
      default: DOut = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      ip_q <= ip_next;
      if (Req) begin
        // Taking an exception discards any concurrent mtc0 or eret.
        exl_q      <= 1'b1;
        bd_q       <= M_DelaySlot;
        exc_code_q <= int_req ? 5'd0 : M_EXCcode;
        epc_q      <= M_DelaySlot ? (M_PC - 32'd4) : M_PC;
      end else begin
        if (WE && (A2 == 5'd12)) begin
          im_q  <= DIn[15:10];
          exl_q <= DIn[1];
          ie_q  <= DIn[0];
        end
        if (WE && (A2 == 5'd14)) begin
          epc_q <= DIn;
        end
        // Later assignment wins: eret beats an mtc0 to SR.EXL in the same cycle.
        if (EXLClr) begin
          exl_q <= 1'b0;
        end
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic count_we;
  logic compare_we;

  assign count_we   = ~Req & WE & (A2 == 5'd9);
  assign compare_we = ~Req & WE & (A2 == 5'd11);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      count_q <= count_we ? DIn : (count_q + 32'd1);
      if (compare_we) begin
        compare_q <= DIn;
        ti_q      <= 1'b0;
      end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
        ti_q <= 1'b1;
      end
    end
  end
`endif

endmodule
